// File: rtl/elm_weight_loader.sv
// elm_weight_loader: streams per-neuron weights then bias from a flat word stream into one ELM layer
// Ports: clk; rst (async, active-low); start/busy/done load control; s_data/s_valid/s_ready
//   stream input; weightValid/weightValue and biasValid/biasValue neuron strobes;
//   config_layer_num/config_neuron_num target select (all-ones when idle);
//   chk_err only when WLOAD_CHECKSUM_EN is defined (trailer word checked against a 32-bit sum).
module elm_weight_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_WEIGHT = 128,
    parameter int NUM_NEURON = 30,
    parameter int LAYER_NO   = 1,
    parameter int CFG_WIDTH  = 2*DATA_WIDTH+1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  weightValid,
    output logic [DATA_WIDTH-1:0] weightValue,
    output logic                  biasValid,
    output logic [DATA_WIDTH-1:0] biasValue,
`ifdef WLOAD_CHECKSUM_EN
    output logic                  chk_err,
`endif
    output logic [CFG_WIDTH-1:0]  config_layer_num,
    output logic [CFG_WIDTH-1:0]  config_neuron_num
);
    localparam int WW = $clog2(NUM_WEIGHT+1);
    localparam int NW = $clog2(NUM_NEURON+1);
    localparam logic [WW-1:0] W_LAST = WW'(NUM_WEIGHT-1);
    localparam logic [NW-1:0] N_LAST = NW'(NUM_NEURON-1);
    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, CHECK, FIN} state_t;
`ifdef WLOAD_CHECKSUM_EN
    localparam state_t AFTER_B = CHECK;
`else
    localparam state_t AFTER_B = FIN;
`endif
    state_t state, state_nx;
    logic [WW-1:0] w_cnt;
    logic [NW-1:0] n_idx;
    logic beat;
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? LOAD_W : IDLE;
            LOAD_W:  state_nx = (beat && w_cnt == W_LAST) ? LOAD_B : LOAD_W;
            LOAD_B:  state_nx = !beat ? LOAD_B : (n_idx < N_LAST) ? LOAD_W : AFTER_B;
            CHECK:   state_nx = beat ? FIN : CHECK;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        s_ready = state == LOAD_W || state == LOAD_B || state == CHECK;
        beat = s_valid && s_ready;
    end
    // config_neuron_num follows n_idx only on weight beats, so it still names the
    // current neuron during its bias strobe and moves with the next neuron's first weight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            weightValid <= 1'b0;
            biasValid <= 1'b0;
            weightValue <= '0;
            biasValue <= '0;
            w_cnt <= '0;
            n_idx <= '0;
            config_layer_num <= '1;
            config_neuron_num <= '1;
        end else begin
            done <= state == FIN;
            weightValid <= beat && state == LOAD_W;
            biasValid <= beat && state == LOAD_B;
            if (state == IDLE && start) begin
                busy <= 1'b1;
                w_cnt <= '0;
                n_idx <= '0;
                config_layer_num <= CFG_WIDTH'(LAYER_NO);
                config_neuron_num <= '0;
            end
            if (beat && state == LOAD_W) begin
                weightValue <= s_data;
                w_cnt <= w_cnt + 1'b1;
                config_neuron_num <= CFG_WIDTH'(n_idx);
            end
            if (beat && state == LOAD_B) begin
                biasValue <= s_data;
                if (n_idx < N_LAST) begin
                    n_idx <= n_idx + 1'b1;
                    w_cnt <= '0;
                end
            end
            if (state == FIN) begin
                busy <= 1'b0;
                config_layer_num <= '1;
                config_neuron_num <= '1;
            end
        end
    end
`ifdef WLOAD_CHECKSUM_EN
    logic [31:0] sum;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
            chk_err <= 1'b0;
        end else if (state == IDLE && start) begin
            sum <= '0;
            chk_err <= 1'b0;
        end else if (beat && state != CHECK) begin
            sum <= sum + 32'(s_data);
        end else if (beat) begin
            chk_err <= s_data != sum[DATA_WIDTH-1:0];
        end
    end
`endif
endmodule
